// File: rtl/axi4l_mst_pkg.sv
// Shared types and constants for the AXI4-Lite host master and its watchdog.
package axi4l_mst_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP
   } state_t;

   localparam logic [1:0]  RESP_OKAY     = 2'b00;
   localparam logic [1:0]  RESP_SLVERR   = 2'b10;
   localparam logic [1:0]  RESP_DECERR   = 2'b11;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   // SLVERR and DECERR both carry resp[1]; OKAY and EXOKAY do not.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/axi4l_mst_watchdog.sv
// Transaction watchdog: counts busy cycles since request acceptance and flags expiry.
// Only instantiated when AXI4L_MST_TIMEOUT_EN is defined.
module axi4l_mst_watchdog
   import axi4l_mst_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic aclk,
   input  logic areset,
   input  logic i_clear,
   input  logic i_active,
   output logic o_expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;
   // Expiry lands the response TIMEOUT_CYCLES cycles after the accept cycle,
   // the same measure as the 3-cycle latency of a zero-wait transaction.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 2);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_active) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_expired = i_active && (r_cnt == LAST_CNT);

endmodule

// File: rtl/axi4l_host_master.sv
// Single-outstanding host-request to AXI4-Lite master bridge.
// Optional hung-slave watchdog enabled by defining AXI4L_MST_TIMEOUT_EN.
module axi4l_host_master
   import axi4l_mst_pkg::*;
#(
   parameter int ADDR_W         = 3,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [2:0]          awprot,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   output logic [2:0]          arprot,
   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp
);

   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_wstrb;
   logic                r_awvalid;
   logic                r_wvalid;
   logic                r_bready;
   logic                r_arvalid;
   logic                r_rready;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic                r_rsp_err;

   logic w_accept;
   logic w_active;
   logic w_aw_done;
   logic w_w_done;
   logic w_expired;

   assign w_accept  = (r_state == IDLE) && req_valid;
   assign w_active  = (r_state != IDLE);
   assign w_aw_done = !r_awvalid || awready;
   assign w_w_done  = !r_wvalid || wready;

`ifdef AXI4L_MST_TIMEOUT_EN
   axi4l_mst_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .aclk      (aclk),
      .areset    (areset),
      .i_clear   (w_accept),
      .i_active  (w_active),
      .o_expired (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   // NOTE: every register here uses <= so all branches read pre-edge values,
   // and the async reset clears the whole datapath, not just the FSM.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_addr  <= req_addr & ADDR_MASK;
                  r_wdata <= req_wdata;
                  r_wstrb <= req_wstrb;
                  if (req_we) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= WR_REQ;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (r_awvalid && awready) r_awvalid <= 1'b0;
               if (r_wvalid && wready)   r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_state  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (bvalid && r_bready) begin
                  r_bready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= resp_is_err(bresp);
                  r_rsp_rdata <= '0;
                  r_state     <= IDLE;
               end
            end
            RD_REQ: begin
               if (r_arvalid && arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (rvalid && r_rready) begin
                  r_rready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= resp_is_err(rresp);
                  r_rsp_rdata <= rdata;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase

         // NOTE: placed after the case so this abort overrides any handshake
         // assignment made in the same cycle (last nonblocking write wins).
         if (w_expired) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= DATA_W'(TIMEOUT_RDATA);
            r_state     <= IDLE;
         end
      end
   end

   assign req_ready = (r_state == IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign awvalid   = r_awvalid;
   assign awaddr    = r_addr;
   assign awprot    = 3'b000;
   assign wvalid    = r_wvalid;
   assign wdata     = r_wdata;
   assign wstrb     = r_wstrb;
   assign bready    = r_bready;
   assign arvalid   = r_arvalid;
   assign araddr    = r_addr;
   assign arprot    = 3'b000;
   assign rready    = r_rready;

endmodule

// File: tb/tb_axi4l_host_master.sv
// Scoreboard bench for axi4l_host_master: directed requests, a configurable AXI slave
// model and a response monitor. The timeout case runs only with AXI4L_MST_TIMEOUT_EN.
module tb_axi4l_host_master;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;
   localparam int TMO    = 16;

   logic              aclk;
   logic              areset;
   logic              req_valid, req_ready, req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wstrb;
   logic              rsp_valid, rsp_err;
   logic [31:0]       rsp_rdata;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic [2:0]        awprot, arprot;
   logic [31:0]       wdata, rdata;
   logic [3:0]        wstrb;
   logic [1:0]        bresp, rresp;

   axi4l_host_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .aclk(aclk), .areset(areset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } rsp_exp_t;

   rsp_exp_t    exp_q[$];
   logic [2:0]  exp_aw_q[$];
   logic [35:0] exp_w_q[$];
   logic [2:0]  exp_ar_q[$];

   int n_checks;
   int n_err;
   int cyc;
   int last_rsp_cyc;
   int last_acc_cyc;

   // slave behaviour knobs
   int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
   logic [1:0]  cfg_bresp, cfg_rresp;
   logic [31:0] cfg_rdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge aclk);
         cyc++;
      end
   end

   // Response monitor: pops one expectation per rsp_valid pulse.
   initial begin
      rsp_exp_t e;
      last_rsp_cyc = -1;
      forever begin
         @(negedge aclk);
         if (!areset && rsp_valid) begin
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected rsp_valid", 64'(rsp_valid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               check("rsp_err", 64'(rsp_err), 64'(e.err));
               if (e.lat > 0) check("rsp latency", 64'(cyc - e.acc), 64'(e.lat));
            end
         end
      end
   end

   // AXI4-Lite slave model; readies/valids change only on the falling edge.
   initial begin
      int aw_wait, w_wait, b_wait, ar_wait, r_wait;
      bit aw_pend, w_pend, b_pend, ar_pend, r_pend;
      bit got_aw, got_w, got_ar, aw_stall, w_stall, ar_stall;
      logic [2:0]  aw_prev, ar_prev;
      logic [35:0] w_prev;
      logic [2:0]  ea;
      logic [35:0] ew;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
      got_aw = 0; got_w = 0; got_ar = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
      aw_prev = 0; ar_prev = 0; w_prev = 0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
            got_aw = 0; got_w = 0; got_ar = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
            continue;
         end
         // B and R use completion flags from the previous falling edge
         if (b_pend) begin
            bvalid = 0; b_pend = 0;
         end else if (got_aw && got_w && !bvalid) begin
            if (b_wait == b_dly) begin bvalid = 1; bresp = cfg_bresp; b_wait = 0; end
            else b_wait++;
         end
         if (bvalid && bready) begin b_pend = 1; got_aw = 0; got_w = 0; end

         if (r_pend) begin
            rvalid = 0; rdata = 0; r_pend = 0;
         end else if (got_ar && !rvalid) begin
            if (r_wait == r_dly) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; r_wait = 0; end
            else r_wait++;
         end
         if (rvalid && rready) begin r_pend = 1; got_ar = 0; end

         if (aw_pend) begin
            check("awvalid drop after handshake", 64'(awvalid), 64'(0));
            awready = 0; aw_pend = 0;
         end else if (aw_stall && awvalid) begin
            check("awaddr stable while stalled", 64'(awaddr), 64'(aw_prev));
         end
         if (!awvalid) aw_wait = 0;
         else if (!awready) begin
            if (aw_wait == aw_dly) awready = 1; else aw_wait++;
         end
         if (awvalid && awready) begin
            aw_pend = 1; aw_wait = 0; got_aw = 1;
            check("awprot", 64'(awprot), 64'(0));
            if (exp_aw_q.size() == 0) check("unexpected AW", 64'(awvalid), 64'(0));
            else begin ea = exp_aw_q.pop_front(); check("awaddr", 64'(awaddr), 64'(ea)); end
         end
         aw_stall = awvalid && !awready;
         aw_prev  = awaddr;

         if (w_pend) begin
            check("wvalid drop after handshake", 64'(wvalid), 64'(0));
            wready = 0; w_pend = 0;
         end else if (w_stall && wvalid) begin
            check("wdata/wstrb stable while stalled", 64'({wstrb, wdata}), 64'(w_prev));
         end
         if (!wvalid) w_wait = 0;
         else if (!wready) begin
            if (w_wait == w_dly) wready = 1; else w_wait++;
         end
         if (wvalid && wready) begin
            w_pend = 1; w_wait = 0; got_w = 1;
            if (exp_w_q.size() == 0) check("unexpected W", 64'(wvalid), 64'(0));
            else begin ew = exp_w_q.pop_front(); check("wstrb/wdata", 64'({wstrb, wdata}), 64'(ew)); end
         end
         w_stall = wvalid && !wready;
         w_prev  = {wstrb, wdata};

         if (ar_pend) begin
            check("arvalid drop after handshake", 64'(arvalid), 64'(0));
            arready = 0; ar_pend = 0;
         end else if (ar_stall && arvalid) begin
            check("araddr stable while stalled", 64'(araddr), 64'(ar_prev));
         end
         if (!arvalid) ar_wait = 0;
         else if (!arready) begin
            if (ar_wait == ar_dly) arready = 1; else ar_wait++;
         end
         if (arvalid && arready) begin
            ar_pend = 1; ar_wait = 0; got_ar = 1;
            check("arprot", 64'(arprot), 64'(0));
            if (exp_ar_q.size() == 0) check("unexpected AR", 64'(arvalid), 64'(0));
            else begin ea = exp_ar_q.pop_front(); check("araddr", 64'(araddr), 64'(ea)); end
         end
         ar_stall = arvalid && !arready;
         ar_prev  = araddr;
      end
   end

   // Presents one request, pushes its expectations at the accepting edge.
   task automatic do_req(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] e_rdata, input logic e_err,
                         input int e_lat, input logic [2:0] e_addr);
      int       n;
      rsp_exp_t e;
      n = 0;
      @(negedge aclk); #2;
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      while (!req_ready && n < 200) begin
         @(negedge aclk); #2;
         n++;
      end
      if (!req_ready) begin
         check("req_ready wait", 64'(req_ready), 64'(1));
         req_valid = 0;
         return;
      end
      e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.acc = cyc;
      exp_q.push_back(e);
      if (we) begin
         exp_aw_q.push_back(e_addr);
         exp_w_q.push_back({ws, wd});
      end else begin
         exp_ar_q.push_back(e_addr);
      end
      last_acc_cyc = cyc;
      @(posedge aclk); #1;
      req_valid = 0;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max) begin
         @(negedge aclk); #3;
         n++;
      end
      if (exp_q.size() != 0) begin
         check("response wait", 64'(exp_q.size()), 64'(0));
         exp_q.delete();
      end
   endtask

   initial begin
      n_checks = 0; n_err = 0; last_acc_cyc = -1;
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
      cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 0;
      areset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;

      repeat (3) @(negedge aclk);
      #2;
      check("reset req_ready", 64'(req_ready), 64'(1));
      check("reset valids/readies/rsp", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err}), 64'(0));
      check("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
      check("reset addr/data regs", 64'({awaddr, araddr, wstrb, wdata}), 64'(0));
      @(negedge aclk); #2;
      areset = 0;

      // zero-wait write
      do_req(1'b1, 3'h4, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 3, 3'h4);
      wait_idle(50);

      // wready 4 cycles after awready; then AW accepted after W
      w_dly = 4;
      do_req(1'b1, 3'h2, 32'hA5A5_0F0F, 4'h3, 32'h0, 1'b0, 7, 3'h0);
      wait_idle(50);
      w_dly = 0; aw_dly = 2;
      do_req(1'b1, 3'h7, 32'h0BAD_F00D, 4'h8, 32'h0, 1'b0, 5, 3'h4);
      wait_idle(50);
      aw_dly = 0;

      // reads: rvalid 2 cycles late, then unaligned address
      r_dly = 2; cfg_rdata = 32'hCAFE_0001;
      do_req(1'b0, 3'h0, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 5, 3'h0);
      wait_idle(50);
      r_dly = 0; cfg_rdata = 32'h3C3C_00FF;
      do_req(1'b0, 3'h3, 32'h0, 4'h0, 32'h3C3C_00FF, 1'b0, 3, 3'h0);
      wait_idle(50);
      repeat (3) @(negedge aclk);
      #2;
      check("rsp held between responses", 64'({rsp_err, rsp_rdata}), 64'({1'b0, 32'h3C3C_00FF}));

      // error responses, second request accepted in the response cycle
      cfg_bresp = 2'b10; cfg_rresp = 2'b11; cfg_rdata = 32'h5555_AAAA;
      do_req(1'b1, 3'h4, 32'hFFFF_0000, 4'hC, 32'h0, 1'b1, 3, 3'h4);
      do_req(1'b0, 3'h5, 32'h0, 4'h0, 32'h5555_AAAA, 1'b1, 3, 3'h4);
      check("accept in rsp_valid cycle", 64'(last_acc_cyc), 64'(last_rsp_cyc));
      wait_idle(50);
      cfg_bresp = 2'b00; cfg_rresp = 2'b00;

`ifdef AXI4L_MST_TIMEOUT_EN
      // hung slave: arready never comes
      ar_dly = 1000;
      do_req(1'b0, 3'h1, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, TMO, 3'h0);
      wait_idle(50);
      exp_ar_q.delete();
      ar_dly = 0; cfg_rdata = 32'h7777_0001;
      do_req(1'b0, 3'h4, 32'h0, 4'h0, 32'h7777_0001, 1'b0, 3, 3'h4);
      wait_idle(50);
`endif

      // reset asserted while stalled in WR_REQ
      aw_dly = 1000; w_dly = 1000;
      do_req(1'b1, 3'h0, 32'h1111_2222, 4'hF, 32'h0, 1'b0, 0, 3'h0);
      @(negedge aclk); #2;
      check("aw/w valid before reset", 64'({awvalid, wvalid}), 64'(2'b11));
      areset = 1;
      #1;
      check("reset drops aw/w valid", 64'({awvalid, wvalid}), 64'(0));
      exp_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
      aw_dly = 0; w_dly = 0;
      @(negedge aclk); #2;
      areset = 0;
      @(negedge aclk); #2;
      check("req_ready after reset release", 64'(req_ready), 64'(1));
      repeat (4) begin
         @(negedge aclk); #2;
         check("no rsp_valid after abort", 64'(rsp_valid), 64'(0));
      end
      do_req(1'b1, 3'h4, 32'h9ABC_DEF0, 4'h1, 32'h0, 1'b0, 3, 3'h4);
      wait_idle(50);

      check("leftover channel expectations", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global time limit: got running, expected finished");
      $fatal(1, "time limit");
   end

endmodule
